// File: rtl/jts16b_busarb.sv
// jts16b_busarb: System 16B main-bus arbiter between the 68000 and the i8751
// MCU's indirect transfers. Runs the BR/BG/BGACK handshake, drives the shared
// strobes/address/data while the MCU owns the bus, counts region wait states
// and enforces a holdoff so the CPU gets a bus cycle between MCU transfers.
module jts16b_busarb #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned HOLDOFF = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        mcu_rq,
  input  logic        mcu_rnw,
  input  logic [22:0] mcu_addr,
  input  logic [15:0] mcu_wdata,
  output logic [15:0] mcu_rdata,
  output logic        mcu_ack,
  output logic        mcu_err,
  output logic        cpu_brn,
  input  logic        cpu_bgn,
  output logic        cpu_bgackn,
  input  logic        cpu_asn,
  output logic        bus_mcu,
  output logic        bus_asn,
  output logic        bus_rnw,
  output logic [22:0] bus_addr,
  output logic [15:0] bus_din,
  input  logic [15:0] bus_dout,
  input  logic        bus_ok,
  input  logic [1:0]  wait_cyc
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [7:0] TO_L   = TIMEOUT[7:0];
  localparam logic [7:0] HOLD_L = HOLDOFF[7:0];

  logic [1:0]  st_q, st_d;
  logic        rnw_q, rnw_d;
  logic [22:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        eflag_q, eflag_d;
  logic        brn_q, brn_d;
  logic        bgackn_q, bgackn_d;
  logic        asn_q, asn_d;
  logic        mcu_q, mcu_d;
  logic [1:0]  wcnt_q, wcnt_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic [7:0]  hold_q, hold_d;
  logic        cpu_asn_q;

  logic [7:0]  tcnt_inc;
  logic [1:0]  wcnt_nx;
  logic        as_rise;

  // Next-state logic for the transfer sequencer, holdoff and timeout counters
  always_comb begin
    st_d     = st_q;
    rnw_d    = rnw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    eflag_d  = eflag_q;
    brn_d    = brn_q;
    bgackn_d = bgackn_q;
    asn_d    = asn_q;
    mcu_d    = mcu_q;
    wcnt_d   = wcnt_q;
    tcnt_d   = tcnt_q;
    hold_d   = hold_q;
    wcnt_nx  = 2'd0;
    tcnt_inc = (tcnt_q == 8'hFF) ? 8'hFF : tcnt_q + 8'd1;
    as_rise  = cpu_asn & ~cpu_asn_q;

    if (cen && hold_q != 8'd0) hold_d = hold_q - 8'd1;
    if (as_rise) hold_d = 8'd0;

    if (cen) begin
      case (st_q)
        ST_IDLE: begin
          if (mcu_rq && hold_q == 8'd0) begin
            rnw_d   = mcu_rnw;
            addr_d  = mcu_addr;
            wdata_d = mcu_wdata;
            eflag_d = 1'b0;
            brn_d   = 1'b0;
            tcnt_d  = 8'd0;
            st_d    = ST_REQ;
          end
        end
        ST_REQ: begin
          if (!cpu_bgn && cpu_asn && bgackn_q) begin
            bgackn_d = 1'b0;
            brn_d    = 1'b1;
            mcu_d    = 1'b1;
            tcnt_d   = 8'd0;
            st_d     = ST_ACCESS;
          end else if (tcnt_inc == TO_L) begin
            // Withdraw BR as soon as we give up rather than a tick later.
            brn_d   = 1'b1;
            eflag_d = 1'b1;
            tcnt_d  = 8'd0;
            st_d    = ST_DONE;
          end else begin
            tcnt_d = tcnt_inc;
          end
        end
        ST_ACCESS: begin
          // The wait count is judged on its post-update value so that the
          // strobe stays low for exactly 1 + wait_cyc ticks.
          if (asn_q) begin
            asn_d   = 1'b0;
            wcnt_nx = wait_cyc;
          end else begin
            wcnt_nx = (wcnt_q != 2'd0) ? wcnt_q - 2'd1 : 2'd0;
          end
          wcnt_d = wcnt_nx;
          if (wcnt_nx == 2'd0 && bus_ok) begin
            if (rnw_q) rdata_d = bus_dout;
            tcnt_d = 8'd0;
            st_d   = ST_DONE;
          end else if (tcnt_inc == TO_L) begin
            eflag_d = 1'b1;
            tcnt_d  = 8'd0;
            st_d    = ST_DONE;
          end else begin
            tcnt_d = tcnt_inc;
          end
        end
        default: begin
          asn_d    = 1'b1;
          mcu_d    = 1'b0;
          bgackn_d = 1'b1;
          brn_d    = 1'b1;
          ack_d    = ~eflag_q;
          err_d    = eflag_q;
          hold_d   = HOLD_L;
          tcnt_d   = 8'd0;
          st_d     = ST_IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= ST_IDLE;
      rnw_q     <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      eflag_q   <= 1'b0;
      brn_q     <= 1'b1;
      bgackn_q  <= 1'b1;
      asn_q     <= 1'b1;
      mcu_q     <= 1'b0;
      wcnt_q    <= '0;
      tcnt_q    <= '0;
      hold_q    <= '0;
      cpu_asn_q <= 1'b1;
    end else begin
      st_q      <= st_d;
      rnw_q     <= rnw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      eflag_q   <= eflag_d;
      brn_q     <= brn_d;
      bgackn_q  <= bgackn_d;
      asn_q     <= asn_d;
      mcu_q     <= mcu_d;
      wcnt_q    <= wcnt_d;
      tcnt_q    <= tcnt_d;
      hold_q    <= hold_d;
      cpu_asn_q <= cpu_asn;
    end
  end

  assign mcu_rdata  = rdata_q;
  assign mcu_ack    = ack_q;
  assign mcu_err    = err_q;
  assign cpu_brn    = brn_q;
  assign cpu_bgackn = bgackn_q;
  assign bus_mcu    = mcu_q;
  assign bus_asn    = asn_q;
  assign bus_rnw    = mcu_q ? rnw_q : 1'b1;
  assign bus_addr   = addr_q;
  assign bus_din    = wdata_q;

endmodule
